iop_mem_bridge: RTL and testbench
=================================

// Module: iop_mem_bridge
// PURPOSE
//   Data-side bridge between the r408 IOP core's byte read/write ports and the
//   32-bit word system bus. It posts one pending write, holds one read-word line
//   buffer, and generates IOPRWAIT/IOPWWAIT for the core. A bus watchdog aborts
//   hung transfers. It sits directly downstream of the IOP core wrapper.
// PARAMETERS
//   ADDR_W   21   IOP byte address width; bus word address is ADDR_W-2 bits
//   TIMEOUT  255  max cycles a bus transfer may wait for mem_ack (1..255)
// PORTS
//   sysclk     in   1        system clock; all state changes on rising edge
//   sysrst     in   1        synchronous, active-high reset
//   iop_raddr  in   ADDR_W   IOP read byte address
//   iop_rd     in   1        IOP read request, held until iop_rwait low
//   iop_rdata  out  8        read byte, valid when iop_rd & !iop_rwait
//   iop_rwait  out  1        stall read
//   iop_waddr  in   ADDR_W   IOP write byte address
//   iop_wdata  in   8        IOP write byte
//   iop_wr     in   1        IOP write request, held until iop_wwait low
//   iop_wwait  out  1        stall write
//   mem_req    out  1        bus request; held with addr/data stable until mem_ack
//   mem_we     out  1        1=write, 0=read
//   mem_addr   out  ADDR_W-2 bus word address
//   mem_be     out  4        byte enables (write); 4'hF on reads
//   mem_wdata  out  32       write byte replicated on all four lanes
//   mem_rdata  in   32       read word, sampled on mem_ack
//   mem_ack    in   1        single-cycle transfer done; ignored in IDLE
//   rbuf_flush in   1        invalidate the read line buffer (DMA coherence)
//   bus_err    out  1        sticky: a transfer timed out
//   err_clr    in   1        clears bus_err (a new timeout in the same cycle wins)
// BEHAVIOUR
//   Reset: FSM=IDLE, wbuf/rbuf invalid, bus_err=0, mem_req=0, mem_we=0,
//     mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0. A transfer in
//     progress is abandoned and the posted write is lost.
//   Read hit = iop_rd & rbuf_valid & rbuf_addr==iop_raddr[ADDR_W-1:2] & !wbuf_valid.
//   iop_rwait = iop_rd & !hit; iop_rdata = rbuf byte raddr[1:0] (0 when no hit).
//     Both are combinational; a hit has zero-cycle latency.
//   iop_wwait = iop_wr & wbuf_valid. Write accept = iop_wr & !wbuf_valid; at the edge
//     it captures waddr/wdata into wbuf and sets wbuf_valid.
//   FSM IDLE: if wbuf_valid -> WR (writes first, preserving order).
//     Else if iop_rd & miss -> RD. Bus outputs register on entry;
//     mem_req rises the cycle after the decision.
//   WR: mem_we=1, mem_be=1<<waddr[1:0], wdata replicated. On mem_ack: clear wbuf.
//     If rbuf holds the same word, update that byte in rbuf (write-through
//     merge). Then -> IDLE.
//   RD: mem_we=0, mem_be=4'hF. On mem_ack: rbuf<=mem_rdata, tag<=word address,
//     set valid. Then -> IDLE; the read hits the next cycle.
//     Minimum miss latency is 2 cycles (rd at T0, ack at T1, data at T2).
//   Watchdog: counter clears on entry to RD/WR and increments each cycle without ack.
//     At count==TIMEOUT-1 with no ack: mem_req drops, bus_err=1, -> IDLE.
//     An aborted read loads rbuf=32'hFFFFFFFF, valid, so the core reads 8'hFF.
//     An aborted write is discarded (wbuf cleared).
//   Write accepted in the same cycle a read misses: the write drains before the read.
//   rbuf_flush clears rbuf_valid. If it coincides with an RD ack, the flush wins:
//     the line is not marked valid and the read re-issues.
//   A write accept and a WR ack in the same cycle cannot occur (accept needs an empty wbuf).
// TESTING
//   1 Reset, then iop_rd raddr=0x00005, mem ack 1 cycle after req with 0xA1B2C3D4
//     -> rwait high 2 cycles, rdata=0xC3, mem_addr=0x00001.
//   2 Read again at raddr=0x00007 -> no bus req, rwait=0 in the same cycle, rdata=0xA1.
//   3 iop_wr waddr=0x00006 wdata=0x5A, then a second wr immediately -> first accepted,
//     second sees wwait=1 until the WR ack. mem_be=4'b0100, mem_wdata=0x5A5A5A5A,
//     rbuf byte 2 becomes 0x5A.
//   4 Write followed by a read miss in the same cycle -> WR bus cycle completes before RD.
//   5 No mem_ack, TIMEOUT=255 -> mem_req drops after 255 cycles, bus_err=1, rdata=0xFF.
//     err_clr -> bus_err=0.
//   6 rbuf_flush coincident with RD ack -> read re-issues. sysrst mid-WR ->
//     mem_req=0 next cycle and the posted write is lost.

Source files
------------

// File: rtl/iop_mem_bridge.sv
// Data-side bridge from the r408 IOP byte read/write ports to the 32-bit word bus.
// One posted write buffer, one read line buffer, and a bus watchdog.
module iop_mem_bridge #(
   parameter int unsigned ADDR_W  = 21,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                sysclk,
   input  logic                sysrst,
   input  logic [ADDR_W-1:0]   iop_raddr,
   input  logic                iop_rd,
   output logic [7:0]          iop_rdata,
   output logic                iop_rwait,
   input  logic [ADDR_W-1:0]   iop_waddr,
   input  logic [7:0]          iop_wdata,
   input  logic                iop_wr,
   output logic                iop_wwait,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-3:0]   mem_addr,
   output logic [3:0]          mem_be,
   output logic [31:0]         mem_wdata,
   input  logic [31:0]         mem_rdata,
   input  logic                mem_ack,
   input  logic                rbuf_flush,
   output logic                bus_err,
   input  logic                err_clr
);
   localparam int unsigned WA_W  = ADDR_W - 2;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

   state_t              state, state_d;
   logic                wbuf_valid, wbuf_valid_d;
   logic [ADDR_W-1:0]   wbuf_addr, wbuf_addr_d;
   logic [7:0]          wbuf_data, wbuf_data_d;
   logic                rbuf_valid, rbuf_valid_d;
   logic [WA_W-1:0]     rbuf_tag, rbuf_tag_d;
   logic [31:0]         rbuf_data, rbuf_data_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                bus_err_d;
   logic                mem_req_d, mem_we_d;
   logic [WA_W-1:0]     mem_addr_d;
   logic [3:0]          mem_be_d;
   logic [31:0]         mem_wdata_d;

   logic                hit, wr_accept, timeout;
   logic [4:0]          rsel;

   // Core-facing handshake is combinational so a line-buffer hit costs no cycle.
   assign hit       = iop_rd & rbuf_valid & (rbuf_tag == iop_raddr[ADDR_W-1:2]) & ~wbuf_valid;
   assign rsel      = {iop_raddr[1:0], 3'b000};
   assign iop_rdata = hit ? rbuf_data[rsel +: 8] : 8'h00;
   assign iop_rwait = iop_rd & ~hit;
   assign iop_wwait = iop_wr & wbuf_valid;
   assign wr_accept = iop_wr & ~wbuf_valid;
   assign timeout   = (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d      = state;
      wbuf_valid_d = wbuf_valid;
      wbuf_addr_d  = wbuf_addr;
      wbuf_data_d  = wbuf_data;
      rbuf_valid_d = rbuf_valid;
      rbuf_tag_d   = rbuf_tag;
      rbuf_data_d  = rbuf_data;
      cnt_d        = cnt;
      bus_err_d    = bus_err;
      mem_req_d    = mem_req;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_be_d     = mem_be;
      mem_wdata_d  = mem_wdata;

      if (wr_accept) begin
         wbuf_valid_d = 1'b1;
         wbuf_addr_d  = iop_waddr;
         wbuf_data_d  = iop_wdata;
      end
      if (err_clr) bus_err_d = 1'b0;

      unique case (state)
         IDLE: begin
            // A write accepted this cycle holds off the read so it drains first.
            if (wbuf_valid) begin
               state_d     = WR;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = wbuf_addr[ADDR_W-1:2];
               mem_be_d    = 4'b0001 << wbuf_addr[1:0];
               mem_wdata_d = {4{wbuf_data}};
               cnt_d       = '0;
            end else if (iop_rwait & ~iop_wr) begin
               state_d    = RD;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = iop_raddr[ADDR_W-1:2];
               mem_be_d   = 4'hF;
               cnt_d      = '0;
            end
         end
         RD: begin
            if (mem_ack | timeout) begin
               rbuf_data_d  = mem_ack ? mem_rdata : 32'hFFFF_FFFF;
               rbuf_tag_d   = mem_addr;
               rbuf_valid_d = 1'b1;
               mem_req_d    = 1'b0;
               bus_err_d    = bus_err_d | ~mem_ack;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         WR: begin
            if (mem_ack | timeout) begin
               if (mem_ack && rbuf_valid && (rbuf_tag == mem_addr))
                  rbuf_data_d[{wbuf_addr[1:0], 3'b000} +: 8] = wbuf_data;
               wbuf_valid_d = 1'b0;
               mem_req_d    = 1'b0;
               bus_err_d    = bus_err_d | ~mem_ack;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush overrides any fill in the same cycle, forcing a re-fetch.
      if (rbuf_flush) rbuf_valid_d = 1'b0;
   end

   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         state      <= IDLE;
         wbuf_valid <= 1'b0;
         wbuf_addr  <= '0;
         wbuf_data  <= '0;
         rbuf_valid <= 1'b0;
         rbuf_tag   <= '0;
         rbuf_data  <= '0;
         cnt        <= '0;
         bus_err    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_d;
         wbuf_valid <= wbuf_valid_d;
         wbuf_addr  <= wbuf_addr_d;
         wbuf_data  <= wbuf_data_d;
         rbuf_valid <= rbuf_valid_d;
         rbuf_tag   <= rbuf_tag_d;
         rbuf_data  <= rbuf_data_d;
         cnt        <= cnt_d;
         bus_err    <= bus_err_d;
         mem_req    <= mem_req_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_be     <= mem_be_d;
         mem_wdata  <= mem_wdata_d;
      end
   end
endmodule

// File: tb/tb_iop_mem_bridge.sv
// Scoreboard bench for iop_mem_bridge: random IOP traffic against a byte-array
// model, with a bus responder that owns a word memory and checks every transfer.
module tb_iop_mem_bridge;
   localparam int unsigned ADDR_W = 21;

   logic                sysclk, sysrst;
   logic [ADDR_W-1:0]   iop_raddr, iop_waddr;
   logic                iop_rd, iop_wr, iop_rwait, iop_wwait;
   logic [7:0]          iop_rdata, iop_wdata;
   logic                mem_req, mem_we, mem_ack;
   logic [ADDR_W-3:0]   mem_addr;
   logic [3:0]          mem_be;
   logic [31:0]         mem_wdata, mem_rdata;
   logic                rbuf_flush, bus_err, err_clr;

   iop_mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
      .sysclk(sysclk), .sysrst(sysrst),
      .iop_raddr(iop_raddr), .iop_rd(iop_rd), .iop_rdata(iop_rdata), .iop_rwait(iop_rwait),
      .iop_waddr(iop_waddr), .iop_wdata(iop_wdata), .iop_wr(iop_wr), .iop_wwait(iop_wwait),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rbuf_flush(rbuf_flush), .bus_err(bus_err), .err_clr(err_clr)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   int total = 0;
   int bad   = 0;

   // Reference state: what the core should observe, and what the bus memory holds.
   logic [7:0]  shadow [0:31];
   logic [31:0] bmem   [0:7];
   logic [7:0]  rq [$];
   logic [12:0] wq [$];

   bit  ack_en = 1'b1;
   int  fixed_dly = 0;
   int  cur_dly = 0;
   int  wait_cnt = 0;
   int  req_cyc = 0;
   int  rd_xfers = 0;
   int  last_rd_addr = -1;
   bit  flush_rand = 1'b0;
   bit  flush_now = 1'b0;
   bit  flush_on_ack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // Issue a read and/or write; expected values are taken in program order.
   task automatic do_rw(input bit dr, input logic [4:0] ra, input bit dw, input logic [4:0] wa,
                        input logic [7:0] wd, input bit ff, output int rwc, output int wwc);
      int  guard;
      bit  rd_done, wr_done;
      rwc = 0;
      wwc = 0;
      if (dw) begin
         wq.push_back({wa, wd});
         shadow[wa] = wd;
      end
      if (dr) rq.push_back(ff ? 8'hFF : shadow[ra]);
      iop_raddr = ADDR_W'(ra);
      iop_waddr = ADDR_W'(wa);
      iop_wdata = wd;
      iop_rd    = dr;
      iop_wr    = dw;
      guard     = 0;
      while ((iop_rd || iop_wr) && guard < 2000) begin
         @(negedge sysclk);
         rd_done = iop_rd && !iop_rwait;
         wr_done = iop_wr && !iop_wwait;
         if (iop_rd && iop_rwait) rwc++;
         if (iop_wr && iop_wwait) wwc++;
         @(posedge sysclk);
         #1;
         if (rd_done) iop_rd = 1'b0;
         if (wr_done) iop_wr = 1'b0;
         guard++;
      end
      if (iop_rd || iop_wr) begin
         check("op_timeout", 64'(guard), 64'(0));
         iop_rd = 1'b0;
         iop_wr = 1'b0;
      end
   endtask

   // Monitor: every completed core read pops one expected byte.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge sysclk);
         if (!sysrst && iop_rd && !iop_rwait) begin
            if (rq.size() == 0) check("rd_unexpected", 64'(iop_rdata), 64'(0));
            else begin
               exp = rq.pop_front();
               check("rdata", 64'(iop_rdata), 64'(exp));
            end
         end
      end
   end

   // Bus responder: acks after a delay, checks transfers, owns bus memory.
   initial begin
      logic [12:0] e;
      logic [4:0]  ea;
      logic [7:0]  ed;
      int          wi;
      forever begin
         @(posedge sysclk);
         #1;
         mem_ack    = 1'b0;
         rbuf_flush = 1'b0;
         if (mem_req) begin
            req_cyc++;
            if (ack_en && wait_cnt >= cur_dly) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
               wi       = int'(mem_addr[2:0]);
               if (mem_we) begin
                  if (wq.size() == 0) check("wr_unexpected", 64'(mem_addr), 64'(0));
                  else begin
                     e  = wq.pop_front();
                     ea = e[12:8];
                     ed = e[7:0];
                     check("wr_xfer", 64'({mem_we, mem_addr, mem_be, mem_wdata}),
                           64'({1'b1, (ADDR_W-2)'(ea[4:2]), 4'(4'b0001 << ea[1:0]), {4{ed}}}));
                  end
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) bmem[wi][8*b +: 8] = mem_wdata[8*b +: 8];
               end else begin
                  rd_xfers++;
                  last_rd_addr = int'(mem_addr);
                  check("rd_be", 64'(mem_be), 64'(4'hF));
                  check("wr_before_rd", 64'(wq.size()), 64'(0));
                  mem_rdata = bmem[wi];
                  if (flush_on_ack) begin
                     rbuf_flush   = 1'b1;
                     flush_on_ack = 1'b0;
                  end
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            cur_dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            if (flush_now || (flush_rand && $urandom_range(0, 15) == 0)) rbuf_flush = 1'b1;
            flush_now = 1'b0;
         end
      end
   end

   initial begin
      int         rwc, wwc, n, g;
      logic [7:0] old;
      sysrst = 1'b1;  iop_rd = 1'b0;  iop_wr = 1'b0;  err_clr = 1'b0;
      iop_raddr = '0; iop_waddr = '0; iop_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0; rbuf_flush = 1'b0;
      for (int w = 0; w < 8; w++) bmem[w] = $urandom;
      bmem[1] = 32'hA1B2_C3D4;
      for (int i = 0; i < 32; i++) shadow[i] = bmem[i / 4][(i % 4) * 8 +: 8];

      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_bus_out", 64'({mem_we, mem_be, mem_addr, mem_wdata}), 64'(0));
      check("rst_bus_err", 64'(bus_err), 64'(0));
      check("rst_waits", 64'({iop_rwait, iop_wwait}), 64'(0));
      @(posedge sysclk);
      #1;
      sysrst = 1'b0;
      idle(1);

      // Miss then hit on the same word.
      fixed_dly = 0;
      n = rd_xfers;
      do_rw(1'b1, 5'h05, 1'b0, 5'h00, 8'h00, 1'b0, rwc, wwc);
      check("miss_rwait_cycles", 64'(rwc), 64'(2));
      check("miss_mem_addr", 64'(last_rd_addr), 64'(1));
      check("miss_xfers", 64'(rd_xfers), 64'(n + 1));
      do_rw(1'b1, 5'h07, 1'b0, 5'h00, 8'h00, 1'b0, rwc, wwc);
      check("hit_rwait_cycles", 64'(rwc), 64'(0));
      check("hit_no_xfer", 64'(rd_xfers), 64'(n + 1));

      // Posted write, back-to-back second write stalls, write-through merge.
      do_rw(1'b0, 5'h00, 1'b1, 5'h06, 8'h5A, 1'b0, rwc, wwc);
      check("wr1_wwait_cycles", 64'(wwc), 64'(0));
      do_rw(1'b0, 5'h00, 1'b1, 5'h09, 8'h33, 1'b0, rwc, wwc);
      check("wr2_wwait_cycles", 64'(wwc), 64'(2));
      idle(4);
      do_rw(1'b1, 5'h06, 1'b0, 5'h00, 8'h00, 1'b0, rwc, wwc);
      check("merge_hit_cycles", 64'(rwc), 64'(0));
      check("merge_no_xfer", 64'(rd_xfers), 64'(n + 1));

      // Write and read miss together: write drains first.
      flush_now = 1'b1;
      idle(3);
      n = rd_xfers;
      do_rw(1'b1, 5'h14, 1'b1, 5'h10, 8'h77, 1'b0, rwc, wwc);
      check("wr_rd_xfers", 64'(rd_xfers), 64'(n + 1));

      // Watchdog abort of a read.
      flush_now = 1'b1;
      idle(3);
      ack_en  = 1'b0;
      req_cyc = 0;
      do_rw(1'b1, 5'h18, 1'b0, 5'h00, 8'h00, 1'b1, rwc, wwc);
      check("timeout_req_cycles", 64'(req_cyc), 64'(255));
      @(negedge sysclk);
      check("timeout_req_low", 64'(mem_req), 64'(0));
      check("timeout_bus_err", 64'(bus_err), 64'(1));
      @(posedge sysclk);
      #1;
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      @(negedge sysclk);
      check("err_clr", 64'(bus_err), 64'(0));
      @(posedge sysclk);
      #1;
      ack_en    = 1'b1;
      flush_now = 1'b1;
      idle(3);

      // Flush coincident with the read fill forces a re-issue.
      n = rd_xfers;
      flush_on_ack = 1'b1;
      do_rw(1'b1, 5'h0B, 1'b0, 5'h00, 8'h00, 1'b0, rwc, wwc);
      check("flush_reissue", 64'(rd_xfers), 64'(n + 2));

      // Reset while a write is on the bus: the write is lost.
      ack_en = 1'b0;
      old    = shadow[13];
      do_rw(1'b0, 5'h00, 1'b1, 5'h0D, ~old, 1'b0, rwc, wwc);
      g = 0;
      while (!mem_req && g < 10) begin
         idle(1);
         g++;
      end
      check("wr_req_up", 64'(mem_req), 64'(1));
      sysrst = 1'b1;
      idle(1);
      sysrst = 1'b0;
      @(negedge sysclk);
      check("rst_mid_wr_req", 64'(mem_req), 64'(0));
      @(posedge sysclk);
      #1;
      wq.delete();
      shadow[13] = old;
      ack_en = 1'b1;
      n = rd_xfers;
      do_rw(1'b1, 5'h0D, 1'b0, 5'h00, 8'h00, 1'b0, rwc, wwc);
      check("rst_refetch", 64'(rd_xfers), 64'(n + 1));

      // Random traffic.
      fixed_dly  = -1;
      flush_rand = 1'b1;
      for (int k = 0; k < 400; k++) begin
         int op;
         op = int'($urandom_range(0, 9));
         do_rw(op < 5 || op == 9, 5'($urandom_range(0, 31)), op >= 5,
               5'($urandom_range(0, 31)), 8'($urandom), 1'b0, rwc, wwc);
      end
      flush_rand = 1'b0;
      idle(10);
      check("rq_drained", 64'(rq.size()), 64'(0));
      check("wq_drained", 64'(wq.size()), 64'(0));
      check("final_bus_err", 64'(bus_err), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
